mdu_div_seq: RTL and testbench

//  Iterative radix-2 restoring divider serving the alpha-pipe MDU; one quotient bit per cycle.

---
 rtl/mdu_div_seq.sv | 146 ++++++++++++++
 tb/tb_mdu_div_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_div_seq.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, result = {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN: skip the iteration when divisor==0 or |dividend| < |divisor|.
module mdu_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         div_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] result,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               done_q, done_d;

  logic               accept;
  logic               is_signed;
  logic [WIDTH-1:0]   dvd_mag;
  logic [WIDTH-1:0]   dvs_mag;
  logic [WIDTH:0]     shifted;
  logic               ge;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    dvd_d    = dvd_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    result_d = result_q;
    done_d   = done_q;

    accept    = (state_q == S_IDLE) && ((div_op == 2'b01) || (div_op == 2'b10));
    is_signed = (div_op == 2'b10);
    dvd_mag   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_mag   = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // Partial remainder is always < |divisor|, so the shifted trial value needs WIDTH+1 bits
    // and the W-bit modular subtraction is exact whenever the trial succeeds.
    shifted = {rem_q, quo_q[WIDTH-1]};
    ge      = (shifted >= {1'b0, dvs_q});

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dvd_d   = dividend;
          dvs_d   = dvs_mag;
          qneg_d  = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg_d  = is_signed && dividend[WIDTH-1];
          dz_d    = (divisor == '0);
          rem_d   = '0;
          quo_d   = dvd_mag;
          cnt_d   = CW'(WIDTH);
          done_d  = 1'b0;
          state_d = S_CALC;
`ifdef DIV_EARLY_OUT_EN
          if ((divisor == '0) || (dvd_mag < dvs_mag)) begin
            rem_d   = dvd_mag;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = S_FIX;
          end
`endif
        end
      end
      S_CALC: begin
        if (ge) begin
          rem_d = shifted[WIDTH-1:0] - dvs_q;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (dz_q) begin
          result_d = {dvd_q, {WIDTH{1'b1}}};
        end else begin
          result_d = {(rneg_q ? -rem_q : rem_q), (qneg_q ? -quo_q : quo_q)};
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      dvd_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      dvd_q    <= dvd_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mdu_div_seq.sv
// Scoreboard bench for mdu_div_seq: expectations queued at accept, checked on each done rising edge.
module tb_mdu_div_seq;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [1:0]     div_op = 2'b00;
  logic [W-1:0]   dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic [2*W-1:0] result;
  logic           done;

  typedef struct {
    logic [2*W-1:0] res;
    int             lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  mdu_div_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .div_op   (div_op),
    .dividend (dividend),
    .divisor  (divisor),
    .result   (result),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb_, q, r;
    if (b == '0) return {a, {W{1'b1}}};
    if (op == 2'b01) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb_ = b;
    q = sa / sb_;
    r = sa % sb_;
    return {r, q};
  endfunction

  function automatic int lat_of(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [W-1:0] ma, mb;
    ma = (op == 2'b10 && a[W-1]) ? -a : a;
    mb = (op == 2'b10 && b[W-1]) ? -b : b;
    if (b == '0 || ma < mb) return 1;
`endif
    return W + 1;
  endfunction

  // Monitor: count negedges with done low, compare on each rising edge of done.
  initial begin
    logic pd;
    int   lc;
    exp_t e;
    pd = 1'b1;
    lc = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pd = 1'b1;
        lc = 0;
      end else begin
        if (!done) lc++;
        if (done && !pd) begin
          if (sb.size() == 0) begin
            check("spurious_done", 64'(sb.size()), 64'd1);
          end else begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("latency", 64'(lc), 64'(e.lat));
          end
          lc = 0;
        end
        pd = done;
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("idle_timeout", 64'(k), 64'd0);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] res);
    exp_t e;
    wait_idle();
    e.res = res;
    e.lat = lat_of(op, a, b);
    sb.push_back(e);
    div_op   = op;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    div_op   = 2'b00;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  initial begin
    logic [1:0] op;
    logic [W-1:0] a, b;
    int k;

    repeat (3) @(negedge clk);
    check("reset_done", 64'(done), 64'd1);
    check("reset_result", result, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    do_op(2'b01, 32'd100, 32'd7, {32'd2, 32'd14});
    do_op(2'b10, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(2'b10, 32'd7, -32'sd2, {32'd1, 32'hFFFF_FFFD});
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    do_op(2'b01, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF});
    do_op(2'b10, 32'h8000_0000, 32'd1, {32'h0, 32'h8000_0000});
    do_op(2'b10, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF});
    do_op(2'b01, 32'd5, 32'd9, {32'd5, 32'd0});
    do_op(2'b01, 32'd9, 32'd5, {32'd4, 32'd1});
    do_op(2'b01, 32'd1234, 32'd0, {32'd1234, 32'hFFFF_FFFF});

    wait_idle();
    repeat (3) @(negedge clk);
    check("hold_idle", result, {32'd1234, 32'hFFFF_FFFF});

    div_op = 2'b11;
    dividend = 32'd50;
    divisor = 32'd5;
    @(negedge clk);
    div_op = 2'b00;
    check("noop_done", 64'(done), 64'd1);
    @(negedge clk);
    check("noop_result", result, {32'd1234, 32'hFFFF_FFFF});

    // A start request in the middle of an operation must be ignored.
    do_op(2'b01, 32'd100, 32'd7, {32'd2, 32'd14});
    repeat (5) @(negedge clk);
    check("busy_result_hold", result, {32'd1234, 32'hFFFF_FFFF});
    div_op = 2'b10;
    dividend = -32'sd7;
    divisor = 32'd2;
    @(negedge clk);
    div_op = 2'b00;

    // Asynchronous abort at iteration 10.
    do_op(2'b01, 32'd1000, 32'd3, {32'd1, 32'd333});
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    sb.delete();
    #1;
    check("async_rst_done", 64'(done), 64'd1);
    check("async_rst_result", result, 64'd0);
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    do_op(2'b10, -32'sd100, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

    for (int i = 0; i < 16; i++) begin
      op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i == 3) b = '0;
      if (i == 5) a = a >> 20;
      do_op(op, a, b, model(op, a, b));
    end

    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
